// File: rtl/jtgng_romarb_pkg.sv
// Shared types for the ROM arbiter: FSM state encoding, slot count and slot index.
package jtgng_romarb_pkg;

  localparam int SLOTS = 4;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic slot_idx_t onehot_to_idx(input logic [SLOTS-1:0] oh);
    slot_idx_t idx;
    idx = 2'd0;
    for (int i = 0; i < SLOTS; i++) begin
      if (oh[i]) begin
        idx = slot_idx_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/jtgng_rom_arb_if.sv
// Requester-side and SDRAM-side bus of the ROM arbiter; master is the arbiter itself.
interface jtgng_rom_arb_if #(
  parameter int AW    = 22,
  parameter int DW    = 32,
  parameter int SLOTS = 4
);
  logic [SLOTS-1:0]         slot_cs;
  logic [SLOTS-1:0][AW-1:0] slot_addr;
  logic [SLOTS-1:0]         slot_ok;
  logic [SLOTS-1:0][DW-1:0] slot_dout;
  logic                     sdram_req;
  logic [AW-1:0]            sdram_addr;
  logic                     sdram_ack;
  logic                     data_rdy;
  logic [DW-1:0]            data_read;
  logic                     refresh_en;

  modport master (
    input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );

  modport slave (
    output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );
endinterface

// File: rtl/jtgng_rr_pick.sv
// Combinational round-robin picker: first requester after the last granted slot wins.
module jtgng_rr_pick
  import jtgng_romarb_pkg::*;
(
  input  logic [SLOTS-1:0] req_i,
  input  slot_idx_t        last_i,
  output logic [SLOTS-1:0] gnt_o
);

  slot_idx_t idx_s;
  logic      found_s;

  // Walk the ring starting one past last_i; the 2-bit index wraps naturally.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    idx_s   = last_i;
    for (int k = 1; k <= SLOTS; k++) begin
      idx_s = last_i + slot_idx_t'(k);
      if (!found_s && req_i[idx_s]) begin
        gnt_o[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/jtgng_rom_arb.sv
// Four-slot SDRAM ROM read arbiter with per-slot result buffers.
// Define JTGNG_ROMARB_CACHE_EN to keep buffers valid as a cache across requests.
module jtgng_rom_arb
  import jtgng_romarb_pkg::*;
#(
  parameter int AW    = 22,
  parameter int DW    = 32,
  parameter int SLOTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic              loop_rst,
  jtgng_rom_arb_if.master   bus
);

  state_t                   state_q, state_d;
  slot_idx_t                last_q, last_d;
  slot_idx_t                gnt_idx_q, gnt_idx_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     req_q, req_d;
  logic                     run_q, run_d;
  logic                     dl_q, dl_d;
  logic [SLOTS-1:0]         valid_q, valid_d;
  logic [SLOTS-1:0][AW-1:0] tag_q, tag_d;
  logic [SLOTS-1:0][DW-1:0] buf_q, buf_d;

  logic [SLOTS-1:0]         ok_s;
  logic [SLOTS-1:0]         pend_s;
  logic [SLOTS-1:0]         gnt_s;

  // A slot hits when its buffer holds the address it is asking for right now.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      ok_s[i] = bus.slot_cs[i] & valid_q[i] & (tag_q[i] == bus.slot_addr[i]);
    end
  end

  assign pend_s = bus.slot_cs & ~ok_s;

  jtgng_rr_pick u_pick (
    .req_i  (pend_s),
    .last_i (last_q),
    .gnt_o  (gnt_s)
  );

  assign bus.slot_ok    = ok_s;
  assign bus.slot_dout  = buf_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.refresh_en = run_q & (state_q == IDLE) & ~(|pend_s) & ~downloading;

  // Next-state and datapath updates for the grant / request / fill sequence.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_idx_d = gnt_idx_q;
    addr_d    = addr_q;
    req_d     = 1'b0;
    run_d     = 1'b1;
    dl_d      = downloading;
    tag_d     = tag_q;
    buf_d     = buf_q;
`ifdef JTGNG_ROMARB_CACHE_EN
    valid_d   = valid_q;
`else
    // Without the cache a result lives only while the requester keeps asking for it.
    valid_d   = ok_s;
`endif
    if (loop_rst) begin
      state_d = IDLE;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((|pend_s) && !downloading) begin
            gnt_idx_d = onehot_to_idx(gnt_s);
            last_d    = gnt_idx_d;
            addr_d    = bus.slot_addr[gnt_idx_d];
            req_d     = 1'b1;
            state_d   = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          if (bus.sdram_ack) begin
            state_d = WAIT;
          end else begin
            req_d = 1'b1;
          end
        end
        WAIT: begin
          if (bus.data_rdy) begin
            buf_d[gnt_idx_q]   = bus.data_read;
            tag_d[gnt_idx_q]   = addr_q;
            valid_d[gnt_idx_q] = 1'b1;
            state_d            = DONE;
          end else begin
            state_d = WAIT;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Contents are stale once a new ROM image has been loaded.
    if (dl_q && !downloading) begin
      valid_d = '0;
    end else begin
      valid_d = valid_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      gnt_idx_q <= 2'd0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      run_q     <= 1'b0;
      dl_q      <= 1'b0;
      valid_q   <= '0;
      tag_q     <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_idx_q <= gnt_idx_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      run_q     <= run_d;
      dl_q      <= dl_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      buf_q     <= buf_d;
    end
  end

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Scoreboard bench for jtgng_rom_arb: stimulus pushes expected SDRAM addresses and
// slot results; monitors pop and compare on sdram_req and slot_ok rising edges.
module tb_jtgng_rom_arb;

`ifdef JTGNG_ROMARB_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  slot;
    logic [31:0] data;
  } okexp_t;

  logic clk, rst, downloading, loop_rst;
  logic hold_rdy;
  int   total, bad, req_cnt;
  int   ph, cnt;

  okexp_t      exp_ok[$];
  logic [21:0] exp_addr[$];
  logic [31:0] mem_q[$];

  jtgng_rom_arb_if #(.AW(22), .DW(32), .SLOTS(4)) bus ();

  jtgng_rom_arb #(.AW(22), .DW(32), .SLOTS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(input int s, input string nm);
    int n = 0;
    while (!bus.slot_ok[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(bus.slot_ok[s]), 64'd1);
  endtask

  // Returns once the DUT has had its request acknowledged (sdram_req fell).
  task automatic wait_wait(input string nm);
    int n = 0;
    while (!bus.sdram_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (bus.sdram_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n < 100), 64'd1);
  endtask

  // SDRAM model: ack one cycle after a request, data two cycles later unless held.
  initial begin
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = 32'd0;
    ph = 0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.sdram_ack = 1'b0;
      bus.data_rdy  = 1'b0;
      if (ph == 0) begin
        if (bus.sdram_req) begin
          bus.sdram_ack = 1'b1;
          ph  = 1;
          cnt = 2;
        end
      end else if (cnt > 0) begin
        cnt--;
      end else if (!hold_rdy) begin
        bus.data_rdy  = 1'b1;
        bus.data_read = (mem_q.size() > 0) ? mem_q.pop_front() : 32'hFFFF_FFFF;
        ph = 0;
      end
    end
  end

  // Monitor: every new request and every new slot result is checked against the queues.
  initial begin
    logic       req_prev;
    logic [3:0] ok_prev;
    okexp_t     e;
    logic [21:0] ea;
    req_prev = 1'b0;
    ok_prev  = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.sdram_req && !req_prev) begin
          req_cnt++;
          if (exp_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL req_unexpected: got addr %h want no request", bus.sdram_addr);
          end else begin
            ea = exp_addr.pop_front();
            chk("sdram_addr", 64'(bus.sdram_addr), 64'(ea));
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (bus.slot_ok[i] && !ok_prev[i]) begin
            if (exp_ok.size() == 0) begin
              total++;
              bad++;
              $display("FAIL ok_unexpected: got ok on slot %0d want none", i);
            end else begin
              e = exp_ok.pop_front();
              chk("ok_slot", 64'(i), 64'(e.slot));
              chk("ok_data", 64'(bus.slot_dout[i]), 64'(e.data));
            end
          end
        end
      end
      req_prev = bus.sdram_req;
      ok_prev  = bus.slot_ok;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    total = 0; bad = 0; req_cnt = 0;
    rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0; hold_rdy = 1'b0;
    bus.slot_cs = 4'd0;
    bus.slot_addr = '0;

    // Reset values.
    step(3);
    @(negedge clk);
    chk("rst_req", 64'(bus.sdram_req), 64'd0);
    chk("rst_addr", 64'(bus.sdram_addr), 64'd0);
    chk("rst_refresh", 64'(bus.refresh_en), 64'd0);
    chk("rst_ok", 64'(bus.slot_ok), 64'd0);
    chk("rst_dout", 64'(|bus.slot_dout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);
    @(negedge clk);
    chk("idle_refresh", 64'(bus.refresh_en), 64'd1);

    // Three slots at once: round-robin from slot 0, one-cycle request latency.
    exp_addr.push_back(22'h100); exp_addr.push_back(22'h200); exp_addr.push_back(22'h300);
    mem_q.push_back(32'hDEAD_BEEF); mem_q.push_back(32'hCAFE_F00D); mem_q.push_back(32'h1234_5678);
    exp_ok.push_back('{2'd0, 32'hDEAD_BEEF});
    exp_ok.push_back('{2'd1, 32'hCAFE_F00D});
    exp_ok.push_back('{2'd2, 32'h1234_5678});
    @(posedge clk); #1;
    bus.slot_addr[0] = 22'h100; bus.slot_addr[1] = 22'h200; bus.slot_addr[2] = 22'h300;
    bus.slot_cs = 4'b0111;
    @(negedge clk);
    chk("lat_req_n", 64'(bus.sdram_req), 64'd0);
    chk("refresh_pend", 64'(bus.refresh_en), 64'd0);
    @(negedge clk);
    chk("lat_req_n1", 64'(bus.sdram_req), 64'd1);
    wait_ok(0, "rr_ok0");
    wait_ok(1, "rr_ok1");
    wait_ok(2, "rr_ok2");
    step(1);
    bus.slot_cs = 4'd0;
    step(2);

    // Same address read twice by slot 2: second read hits only with the cache.
    r0 = req_cnt;
    exp_addr.push_back(22'h1234);
    mem_q.push_back(32'hA5A5_0001);
    exp_ok.push_back('{2'd2, 32'hA5A5_0001});
    bus.slot_addr[2] = 22'h1234;
    bus.slot_cs = 4'b0100;
    wait_ok(2, "hit_ok1");
    step(1);
    bus.slot_cs = 4'd0;
    step(3);
    if (!CACHE) begin
      exp_addr.push_back(22'h1234);
      mem_q.push_back(32'hA5A5_0002);
    end
    exp_ok.push_back('{2'd2, CACHE ? 32'hA5A5_0001 : 32'hA5A5_0002});
    bus.slot_cs = 4'b0100;
    wait_ok(2, "hit_ok2");
    step(3);
    chk("hit_reqs", 64'(req_cnt - r0), CACHE ? 64'd1 : 64'd2);
    bus.slot_cs = 4'd0;
    step(2);

    // Address change while in flight: old data never reported, new address re-fetched.
    hold_rdy = 1'b1;
    exp_addr.push_back(22'h10); exp_addr.push_back(22'h11);
    mem_q.push_back(32'h0000_0010); mem_q.push_back(32'h0000_0011);
    exp_ok.push_back('{2'd0, 32'h0000_0011});
    bus.slot_addr[0] = 22'h10;
    bus.slot_cs = 4'b0001;
    wait_wait("chg_wait");
    @(posedge clk); #1;
    bus.slot_addr[0] = 22'h11;
    hold_rdy = 1'b0;
    wait_ok(0, "chg_ok");
    chk("chg_dout", 64'(bus.slot_dout[0]), 64'h11);

    // Download blocks grants and refresh; its fall invalidates earlier hits.
    @(posedge clk); #1;
    downloading = 1'b1;
    bus.slot_addr[3] = 22'h3333;
    bus.slot_cs = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("dl_req", 64'(bus.sdram_req), 64'd0);
      chk("dl_refresh", 64'(bus.refresh_en), 64'd0);
    end
    exp_addr.push_back(22'h3333); exp_addr.push_back(22'h11);
    mem_q.push_back(32'h3333_0003); mem_q.push_back(32'h1111_0000);
    exp_ok.push_back('{2'd3, 32'h3333_0003});
    exp_ok.push_back('{2'd0, 32'h1111_0000});
    @(posedge clk); #1;
    downloading = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dl_clear", 64'(bus.slot_ok[0]), 64'd0);
    wait_ok(3, "dl_ok3");
    wait_ok(0, "dl_ok0");
    step(1);
    bus.slot_cs = 4'd0;
    step(3);

    // loop_rst during WAIT: back to idle, the late data_rdy is dropped.
    hold_rdy = 1'b1;
    exp_addr.push_back(22'h4444);
    mem_q.push_back(32'h4444_4444);
    bus.slot_addr[2] = 22'h4444;
    bus.slot_cs = 4'b0100;
    wait_wait("lr_wait");
    @(posedge clk); #1;
    loop_rst = 1'b1;
    bus.slot_cs = 4'd0;
    @(posedge clk); #1;
    loop_rst = 1'b0;
    @(negedge clk);
    chk("lr_refresh", 64'(bus.refresh_en), 64'd1);
    chk("lr_req", 64'(bus.sdram_req), 64'd0);
    hold_rdy = 1'b0;
    step(6);
    chk("lr_dout", 64'(bus.slot_dout[2]), CACHE ? 64'hA5A5_0001 : 64'hA5A5_0002);

    // Reset while slot 1 waits for data.
    hold_rdy = 1'b1;
    exp_addr.push_back(22'h2020);
    mem_q.push_back(32'hBAD0_0001);
    bus.slot_addr[1] = 22'h2020;
    bus.slot_cs = 4'b0010;
    wait_wait("rw_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rw_req", 64'(bus.sdram_req), 64'd0);
    chk("rw_addr", 64'(bus.sdram_addr), 64'd0);
    chk("rw_refresh", 64'(bus.refresh_en), 64'd0);
    chk("rw_ok", 64'(bus.slot_ok), 64'd0);
    chk("rw_dout", 64'(|bus.slot_dout), 64'd0);
    @(posedge clk); #1;
    bus.slot_cs = 4'd0;
    rst = 1'b0;
    hold_rdy = 1'b0;
    step(6);
    @(negedge clk);
    chk("rw_ign_dout", 64'(bus.slot_dout[1]), 64'd0);
    chk("rw_ign_req", 64'(bus.sdram_req), 64'd0);
    chk("rw_refresh_after", 64'(bus.refresh_en), 64'd1);

    chk("sb_addr_drain", 64'(exp_addr.size()), 64'd0);
    chk("sb_ok_drain", 64'(exp_ok.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtgng_rom_arb.md
JTGNG_ROM_ARB -- requirements
Module: jtgng_rom_arb

Interface
REQ-001 SHALL have parameters: AW, 22, SDRAM word address width; DW, 32, SDRAM read data width; SLOTS, 4, number of requesters (fixed 4 in this revision).
REQ-002 SHALL have ports: clk  in  1  system clock (48 MHz); rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: downloading  in  1  ROM download active; loop_rst  in  1  synchronous flush of arbiter state.
REQ-004 SHALL have ports: slot_cs  in  4  per-slot request; slot_addr  in  4xAW  per-slot word address; slot_ok  out  4  per-slot data valid; slot_dout  out  4xDW  per-slot read data.
REQ-005 SHALL have ports: sdram_req  out  1  request to SDRAM controller; sdram_addr  out  AW  request address; sdram_ack  in  1  request accepted; data_rdy  in  1  read data valid; data_read  in  DW  read data; refresh_en  out  1  refresh permitted.

Function
REQ-006 SHALL be a 4-state FSM: IDLE, REQ, WAIT, DONE.
REQ-007 IDLE: pending slot = cs high and not hit (REQ-013); if any pending and downloading=0, SHALL grant one, latch its addr into sdram_addr, go to REQ next cycle.
REQ-008 Grant SHALL be round-robin: search starts at slot after last granted; after reset last granted = 3 (slot 0 first).
REQ-009 REQ: sdram_req=1; on sdram_ack go to WAIT, sdram_req=0 the same edge; sdram_addr held stable throughout REQ.
REQ-010 WAIT: on data_rdy latch data_read into granted slot buffer with tag = granted addr, valid=1; go to DONE.
REQ-011 DONE: one cycle, then IDLE; new grant earliest in following IDLE cycle.
REQ-012 slot_ok[i] SHALL be combinational: cs[i] & valid[i] & (tag[i]==slot_addr[i]); slot_dout[i] = buffer[i] at all times.
REQ-013 Hit: a slot with slot_ok[i]=1 SHALL NOT be granted.
REQ-014 Latency, no contention, cache miss: cs seen in IDLE cycle n -> sdram_req at n+1; slot_ok one cycle after data_rdy.
REQ-015 cs dropped while its transaction is in flight: transaction SHALL complete and fill buffer; ok stays low while cs low.
REQ-016 Addr changed while in flight: buffer filled with old tag; ok low (tag mismatch); slot re-pending in next IDLE.
REQ-017 refresh_en SHALL be 1 only in IDLE with no pending slot and downloading=0.
REQ-018 downloading=1: no new grant, sdram_req from an in-flight REQ held until ack, all valid cleared when downloading falls.
REQ-019 loop_rst=1: FSM to IDLE, valid cleared, sdram_req=0, rotation pointer kept; an unfinished data_rdy afterwards SHALL be ignored.
REQ-020 Simultaneous data_rdy and cs change same cycle: buffer write uses granted (latched) addr, never live slot_addr.

Reset
REQ-021 On rst: state=IDLE, sdram_req=0, sdram_addr=0, refresh_en=0, valid=0 all slots, slot_ok=0, buffers=0, last granted=3.
REQ-022 Release of rst SHALL not issue a request before first clk edge with rst low.

Configuration
REQ-023 Macro JTGNG_ROMARB_CACHE_EN defined: REQ-012/013 hit logic as specified.
REQ-024 Macro undefined: valid cleared on leaving DONE+1 cycle after ok; every new cs rising edge or addr change forces an SDRAM access; slot_ok = cs & valid & tag match for exactly the granted result only.

Structure
REQ-025 Package jtgng_romarb_pkg SHALL hold state enum (IDLE/REQ/WAIT/DONE), SLOTS constant, slot-index typedef.
REQ-026 One sub-module jtgng_rr_pick (4-bit request vector + last grant -> one-hot grant, combinational) SHALL be used.

Verification
REQ-027 Reset mid-WAIT: slot1 in flight, assert rst -> all outputs REQ-021 values, later data_rdy ignored.
REQ-028 Slots 0,1,2 cs together, addr 0x100/0x200/0x300 -> sdram_addr sequence 0x100,0x200,0x300; each ok after its data_rdy with data_read 0xDEADBEEF etc.
REQ-029 Cache hit: slot2 reads 0x1234 twice (cs low between) with CACHE_EN -> only one sdram_req; without -> two.
REQ-030 Addr change in flight: slot0 0x10 then 0x11 before data_rdy -> no ok for 0x10, second request to 0x11, ok with its data.
REQ-031 downloading=1 with slot3 pending -> sdram_req stays 0, refresh_en 0; after fall -> request issued, all earlier hits miss.
